// File: rtl/serial_subtractor4_pkg.sv
// sub_pkg: state encoding and counter-width helper for the serial subtractor
package sub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/serial_subtractor4_full_sub1.sv
// full_sub1: combinational one-bit full subtractor
module full_sub1 (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/serial_subtractor4.sv
// serial_subtractor4: bit-serial a - b - bin, LSB first, with start/busy/done framing
module serial_subtractor4 import sub_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);
  localparam int CW = clog2(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d, shifted;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, bout_q, bout_d, busy_q, busy_d, done_q, done_d;
  logic shifting, accept, last, d, bo;
  full_sub1 u_cell (.a(a_q[0]), .b(b_q[0]), .bi(br_q), .d(d), .bo(bo));
  always_comb begin
    shifting = state_q == SHIFT;
    accept   = !shifting && start;
    last     = shifting && cnt_q == CW'(WIDTH - 1);
    shifted  = {d, r_q[WIDTH-1:1]};
    state_d  = accept ? SHIFT : last ? DONE : shifting ? SHIFT : IDLE;
    a_d      = accept ? a : shifting ? a_q >> 1 : a_q;
    b_d      = accept ? b : shifting ? b_q >> 1 : b_q;
    r_d      = accept ? '0 : shifting ? shifted : r_q;
    br_d     = accept ? bin : shifting ? bo : br_q;
    cnt_d    = accept ? '0 : shifting ? cnt_q + 1'b1 : cnt_q;
    diff_d   = last ? shifted : diff_q;
    bout_d   = last ? bo : bout_q;
    busy_d   = state_d == SHIFT;
    done_d   = last;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign diff = diff_q;
  assign bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_serial_subtractor4.sv
// tb_serial_subtractor4: directed and swept checks of the serial subtractor against an arithmetic model
module tb_serial_subtractor4;
  logic clk = 0, rst = 1, start = 0, bin = 0;
  logic [3:0] a = 0, b = 0, diff;
  logic bout, busy, done;
  logic start8 = 0, bin8 = 0;
  logic [7:0] a8 = 0, b8 = 0, diff8;
  logic bout8, busy8, done8;
  int checks = 0, failures = 0, cyc = 0, done_cnt = 0;
  int m_rem;
  logic [3:0] m_diff, e_diff;
  logic m_bout, e_bout, m_done;

  serial_subtractor4 #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .diff(diff), .bout(bout), .busy(busy), .done(done));
  serial_subtractor4 #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .diff(diff8), .bout(bout8), .busy(busy8), .done(done8));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  <= 0;
      m_diff <= 0;
      m_bout <= 0;
      m_done <= 0;
      e_diff <= 0;
      e_bout <= 0;
    end else begin
      m_done <= 0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_diff <= e_diff;
          m_bout <= e_bout;
          m_done <= 1;
        end
      end else if (start) begin
        {e_bout, e_diff} <= {1'b0, a} - {1'b0, b} - {4'b0, bin};
        m_rem <= 4;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (done === 1'b1) done_cnt++;
    if (!rst) begin
      chk("model_busy", busy, m_rem > 0);
      chk("model_done", done, m_done);
      chk("model_diff", diff, m_diff);
      chk("model_bout", bout, m_bout);
    end
  end

  task automatic wait_done(input string nm);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      #1;
      if (done) break;
    end
    chk({nm, "_timeout"}, done, 1);
  endtask

  task automatic op4(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                     input logic [3:0] ed, input logic eb, input string nm);
    @(negedge clk);
    #1;
    a = ia; b = ib; bin = ibin; start = 1;
    @(negedge clk);
    #1;
    start = 0;
    wait_done(nm);
    chk({nm, "_diff"}, diff, ed);
    chk({nm, "_bout"}, bout, eb);
  endtask

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
    logic [8:0] r;
    r = {1'b0, ia} - {1'b0, ib} - {8'b0, ibin};
    @(negedge clk);
    #1;
    a8 = ia; b8 = ib; bin8 = ibin; start8 = 1;
    @(negedge clk);
    #1;
    start8 = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      #1;
      if (done8) break;
    end
    chk("w8_timeout", done8, 1);
    chk("w8_diff", diff8, r[7:0]);
    chk("w8_bout", bout8, r[8]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] r;
    int n0, c0, c1;
    logic [3:0] ha [3], hb [3], hd [3];
    logic hbin [3], hbo [3];
    ha = '{4'd10, 4'd2, 4'd7}; hb = '{4'd4, 4'd6, 4'd7}; hbin = '{1'b1, 1'b0, 1'b1};
    hd = '{4'd5, 4'd12, 4'd15}; hbo = '{1'b0, 1'b1, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #1 rst = 0;
    op4(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, "t9m3");
    op4(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, "t3m9");
    op4(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, "t0m0b");
    op4(4'd15, 4'd15, 1'b0, 4'd0, 1'b0, "t15m15");
    @(negedge clk);
    #1;
    a = 5; b = 2; bin = 0; start = 1;
    @(negedge clk);
    #1;
    n0 = done_cnt;
    a = 1; b = 7; bin = 1;
    @(negedge clk);
    #1;
    a = 12; b = 3; bin = 0;
    @(negedge clk);
    #1;
    start = 0;
    repeat (8) @(negedge clk);
    #1;
    chk("ign_done_pulses", done_cnt - n0, 1);
    chk("ign_diff", diff, 3);
    chk("ign_bout", bout, 0);
    @(negedge clk);
    #1;
    a = 7; b = 1; bin = 0; start = 1;
    @(negedge clk);
    #1;
    start = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst_diff", diff, 0);
    chk("arst_bout", bout, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    #1 rst = 0;
    n0 = done_cnt;
    repeat (8) @(negedge clk);
    #1;
    chk("arst_no_done", done_cnt - n0, 0);
    op4(4'd8, 4'd5, 1'b1, 4'd2, 1'b0, "post_rst");
    @(negedge clk);
    #1;
    a = ha[0]; b = hb[0]; bin = hbin[0]; start = 1;
    c0 = 0;
    for (int i = 0; i < 3; i++) begin
      wait_done("held");
      chk("held_diff", diff, hd[i]);
      chk("held_bout", bout, hbo[i]);
      c1 = cyc;
      if (i > 0) chk("held_period", c1 - c0, 5);
      c0 = c1;
      if (i < 2) begin
        a = ha[i+1]; b = hb[i+1]; bin = hbin[i+1];
      end else start = 0;
    end
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      r = {1'b0, v[7:4]} - {1'b0, v[3:0]} - {4'b0, v[8]};
      op4(v[7:4], v[3:0], v[8], r[3:0], r[4], "sweep4");
    end
    op8(8'd200, 8'd55, 1'b0);
    op8(8'd0, 8'd0, 1'b1);
    op8(8'd255, 8'd255, 1'b1);
    for (int i = 0; i < 100; i++)
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
